// File: rtl/digital_tube_pkg.sv
// Shared types and constants for the 7-segment display sequencing blocks.
package digital_tube_pkg;

    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_MAX   = 9999;
    localparam int ITER_LAST  = BIN_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } dt_state_e;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dt_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// The first tick appears CLK_DIV cycles after reset release; CLK_DIV=1
// keeps the tick permanently high.
module dt_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    // Count 0..CLK_DIV-1 and register the tick on the wrap cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/digital_tube_ctrl.sv
// Binary-to-BCD sequencing controller for the 4-digit scanned display.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a value; val_ready high
// CONV    | one shift-add-3 iteration per cycle, 14 iterations
// LOAD    | publish all four digits on one edge, back to IDLE
module digital_tube_ctrl
    import digital_tube_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             val_valid,
    output logic             val_ready,
    input  logic [BIN_W-1:0] val_data,
    output logic             scan_en,
    output logic [3:0]       single_digit,
    output logic [3:0]       ten_digit,
    output logic [3:0]       hundred_digit,
    output logic [3:0]       kilo_digit,
    output logic             busy,
    output logic             ovf
);

    localparam int SH_W = BCD_W + BIN_W;
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(DISP_MAX);

    dt_state_e         r_state;
    dt_state_e         w_state_nxt;
    logic [3:0]        r_iter;
    logic [SH_W-1:0]   r_shift;
    logic [BCD_W-1:0]  r_digits;
    logic              r_ovf;

    logic              w_over;
    logic [BIN_W-1:0]  w_sat;
    logic [SH_W-1:0]   w_adj;
    logic [SH_W-1:0]   w_shift_step;

    // Out-of-range values saturate so the display reads 9999.
    assign w_over       = (val_data > MAX_BIN);
    assign w_sat        = w_over ? MAX_BIN : val_data;
    assign w_adj        = {bcd_add3(r_shift[SH_W-1:BIN_W]), r_shift[BIN_W-1:0]};
    assign w_shift_step = {w_adj[SH_W-2:0], 1'b0};

    dt_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .tick (scan_en)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (val_valid) w_state_nxt = ST_CONV;
            ST_CONV: if (r_iter == 4'(ITER_LAST)) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Conversion datapath: capture at accept, iterate in CONV, publish in LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_iter   <= '0;
            r_shift  <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (val_valid) begin
                        r_shift <= {{BCD_W{1'b0}}, w_sat};
                        r_iter  <= '0;
                        r_ovf   <= w_over;
                    end
                end
                ST_CONV: begin
                    r_shift <= w_shift_step;
                    r_iter  <= r_iter + 4'd1;
                end
                ST_LOAD: begin
                    r_digits <= r_shift[SH_W-1:BIN_W];
                end
                default: begin
                end
            endcase
        end
    end

    assign val_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign ovf           = r_ovf;
    assign single_digit  = r_digits[3:0];
    assign ten_digit     = r_digits[7:4];
    assign hundred_digit = r_digits[11:8];
    assign kilo_digit    = r_digits[15:12];

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Self-checking bench: two controllers (CLK_DIV=4 and CLK_DIV=1) share the
// same stimulus and are compared every cycle against an arithmetic model.
module tb_digital_tube_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        val_valid;
    logic [13:0] val_data;

    logic        val_ready, scan_en, busy, ovf;
    logic [3:0]  single_digit, ten_digit, hundred_digit, kilo_digit;
    logic        val_ready1, scan_en1, busy1, ovf1;
    logic [3:0]  single_digit1, ten_digit1, hundred_digit1, kilo_digit1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    int m_rem;
    int m_pend;
    int m_disp;
    int m_ovf;
    int m_k;

    always #5 clk = ~clk;

    digital_tube_ctrl #(.CLK_DIV(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .val_valid     (val_valid),
        .val_ready     (val_ready),
        .val_data      (val_data),
        .scan_en       (scan_en),
        .single_digit  (single_digit),
        .ten_digit     (ten_digit),
        .hundred_digit (hundred_digit),
        .kilo_digit    (kilo_digit),
        .busy          (busy),
        .ovf           (ovf)
    );

    digital_tube_ctrl #(.CLK_DIV(1)) dut1 (
        .clk           (clk),
        .rstn          (rstn),
        .val_valid     (val_valid),
        .val_ready     (val_ready1),
        .val_data      (val_data),
        .scan_en       (scan_en1),
        .single_digit  (single_digit1),
        .ten_digit     (ten_digit1),
        .hundred_digit (hundred_digit1),
        .kilo_digit    (kilo_digit1),
        .busy          (busy1),
        .ovf           (ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check_all();
        logic [15:0] exp_d;
        exp_d = to_bcd(m_disp);
        chk("digits4", {kilo_digit, hundred_digit, ten_digit, single_digit}, exp_d);
        chk("ovf4",    ovf,       32'(m_ovf));
        chk("busy4",   busy,      32'(m_rem != 0));
        chk("ready4",  val_ready, 32'(m_rem == 0));
        chk("scan4",   scan_en,   32'((m_k >= 4) && (m_k % 4 == 0)));
        chk("digits1", {kilo_digit1, hundred_digit1, ten_digit1, single_digit1}, exp_d);
        chk("ovf1",    ovf1,       32'(m_ovf));
        chk("busy1",   busy1,      32'(m_rem != 0));
        chk("ready1",  val_ready1, 32'(m_rem == 0));
        chk("scan1",   scan_en1,   32'(m_k >= 1));
    endtask

    // One clock: the model consumes the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        if (rstn) begin
            m_k++;
            if (m_rem == 0) begin
                if (val_valid) begin
                    m_pend = (int'(val_data) > 9999) ? 9999 : int'(val_data);
                    m_ovf  = (int'(val_data) > 9999) ? 1 : 0;
                    m_rem  = 15;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_disp = m_pend;
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rstn   = 1'b0;
        m_rem  = 0;
        m_disp = 0;
        m_ovf  = 0;
        m_k    = 0;
        #1;
        check_all();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rstn = 1'b1;
    endtask

    task automatic send(input int v);
        val_valid = 1'b1;
        val_data  = 14'(v);
        step();
        val_valid = 1'b0;
        repeat (16) step();
    endtask

    initial begin
        val_valid = 1'b0;
        val_data  = '0;
        m_pend    = 0;
        do_reset(2);
        repeat (10) step();

        send(1234);
        send(9999);
        send(10000);
        send(0);

        // Valid held high while busy; data changes at t5.
        val_valid = 1'b1;
        val_data  = 14'd42;
        repeat (5) step();
        val_data = 14'd7;
        repeat (30) step();
        val_valid = 1'b0;
        repeat (20) step();

        // Reset in the middle of a conversion.
        val_valid = 1'b1;
        val_data  = 14'd5678;
        step();
        val_valid = 1'b0;
        repeat (6) step();
        do_reset(2);
        repeat (3) step();
        send(5678);

        repeat (400) begin
            val_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) val_data = 14'($urandom_range(9990, 16383));
            else                           val_data = 14'($urandom_range(0, 16383));
            step();
        end
        val_valid = 1'b0;
        repeat (16) step();

        send(16383);
        send(9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
